rd2r_sram_fifo: RTL and testbench
=================================

RD2R_SRAM_FIFO -- requirements
Module: rd2r_sram_fifo

Interface
REQ-001 SHALL have parameter dataWidth, default 1026, meaning width of each FIFO entry.
REQ-002 SHALL have parameter DEPTH, default 256, meaning SRAM entries (power of two).
REQ-003 SHALL have port CK  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port I_VALID  input  1  meaning push request.
REQ-006 SHALL have port I_READY  output  1  meaning push accepted when I_VALID && I_READY.
REQ-007 SHALL have port I_DATA  input  dataWidth  meaning push data.
REQ-008 SHALL have port O_VALID  output  1  meaning head entry available.
REQ-009 SHALL have port O_READY  input  1  meaning pop when O_VALID && O_READY.
REQ-010 SHALL have port O_DATA  output  dataWidth  meaning head entry data.
REQ-011 SHALL have port LEVEL  output  $clog2(DEPTH+3)  meaning total entries held (SRAM + in-flight + output buffer).
REQ-012 SHALL have port INIT_DONE  output  1  meaning storage usable.
REQ-013 SHALL have ports MEM_REN, MEM_WEN  output  1  meaning active-high read/write strobes to the two-port SRAM wrapper.
REQ-014 SHALL have ports MEM_RA, MEM_WA  output  $clog2(DEPTH)  meaning SRAM read/write address.
REQ-015 SHALL have port MEM_DI  output  dataWidth  meaning SRAM write data; MEM_DOUT  input  dataWidth  meaning SRAM read data.

Function
REQ-016 SHALL write on push: MEM_WEN=1, MEM_WA=wptr, MEM_DI=I_DATA in the same cycle; wptr increments modulo DEPTH.
REQ-017 SHALL drive I_READY = INIT_DONE && (sram_count < DEPTH).
REQ-018 SHALL treat MEM_DOUT as valid exactly one cycle after MEM_REN and capture it into a 2-entry output buffer on that cycle's edge.
REQ-019 SHALL assert MEM_REN, MEM_RA=rptr when sram_count>0 and (outbuf_count + inflight) < 2; rptr increments modulo DEPTH.
REQ-020 SHALL present the oldest output-buffer entry on O_DATA; O_VALID = outbuf_count>0.
REQ-021 SHALL sustain one push and one pop per cycle in steady state.
REQ-022 SHALL produce O_VALID no earlier than the 3rd edge after the push edge into an empty FIFO (write, read, capture).
REQ-023 SHALL update sram_count by +1 on push, -1 on read issue, unchanged when both occur.
REQ-024 SHALL never issue read and write to the same address in one cycle (guaranteed by count gating; assertion required).
REQ-025 SHALL keep O_DATA stable while O_VALID && !O_READY.
REQ-026 SHALL keep MEM_REN/MEM_WEN low when not reading/writing; MEM_RA/MEM_WA/MEM_DI don't-care then.

Reset
REQ-027 SHALL on RST clear wptr, rptr, sram_count, inflight, outbuf_count; O_VALID=0, I_READY=0 during reset, LEVEL=0, MEM_REN=MEM_WEN=0.
REQ-028 SHALL on RST mid-operation discard all contents and drop any in-flight MEM_DOUT on the following cycle.

Configuration
REQ-029 SHALL with RD2R_SRAM_FIFO_MEMINIT_EN defined run FSM states INIT->RUN: after RST enter INIT, write zero to addresses 0..DEPTH-1 (one per cycle, MEM_WEN=1), INIT_DONE=0; go to RUN after address DEPTH-1; RST in INIT restarts at address 0.
REQ-030 SHALL without RD2R_SRAM_FIFO_MEMINIT_EN enter RUN directly; INIT_DONE=1 the first cycle after RST deasserts.

Structure
REQ-031 SHALL place DEPTH default, dataWidth default and the state enum (INIT, RUN) in package rd2r_sram_fifo_pkg.
REQ-032 SHALL implement the 2-entry output buffer as sub-module rd2r_sram_fifo_obuf; SRAM wrapper instantiated by the parent, not inside this block.

Verification
REQ-033 SHALL cover: empty FIFO, push 0x155 once, O_READY=1 -> O_VALID rises on 3rd edge after push, O_DATA=0x155, LEVEL back to 0.
REQ-034 SHALL cover: 258 pushes with O_READY=0 -> I_READY falls after 258th accepted (256 SRAM + 2 buffer), LEVEL=258; pops return 0..257 in order.
REQ-035 SHALL cover: continuous push/pop of incrementing data for 1000 cycles -> one pop per cycle after fill, no loss, pointer wrap past 255.
REQ-036 SHALL cover: RST asserted with 10 entries and one read in flight -> next cycle O_VALID=0, LEVEL=0; following push returns only new data.
REQ-037 SHALL cover: with RD2R_SRAM_FIFO_MEMINIT_EN, RST -> exactly 256 MEM_WEN cycles, addresses 0..255, MEM_DI=0, INIT_DONE rises the following cycle, I_READY low throughout.

Source files
------------

// File: rtl/rd2r_sram_fifo_pkg.sv
// Shared defaults and the storage-init state type for the SRAM-backed FIFO.
package rd2r_sram_fifo_pkg;
    localparam int unsigned DEPTH_DEFAULT      = 256;
    localparam int unsigned DATA_WIDTH_DEFAULT = 1026;

    typedef enum logic {
        INIT,
        RUN
    } state_e;
endpackage

// File: rtl/rd2r_sram_fifo_if.sv
// Push/pop handshake bundle of the SRAM-backed FIFO; slave is the FIFO side.
interface rd2r_sram_fifo_if
    import rd2r_sram_fifo_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH_DEFAULT
);
    logic                 I_VALID;
    logic                 I_READY;
    logic [dataWidth-1:0] I_DATA;
    logic                 O_VALID;
    logic                 O_READY;
    logic [dataWidth-1:0] O_DATA;

    modport master (
        output I_VALID, I_DATA, O_READY,
        input  I_READY, O_VALID, O_DATA
    );

    modport slave (
        input  I_VALID, I_DATA, O_READY,
        output I_READY, O_VALID, O_DATA
    );
endinterface

// File: rtl/rd2r_sram_fifo_obuf.sv
// Two-entry output buffer that catches SRAM read data and presents the oldest entry.
module rd2r_sram_fifo_obuf
    import rd2r_sram_fifo_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [dataWidth-1:0] wr_data,
    input  logic                 rd_en,
    output logic [dataWidth-1:0] rd_data,
    output logic                 valid,
    output logic [1:0]           count
);
    logic [dataWidth-1:0] slot [2];
    logic                 head;
    logic                 tail;

    // with two entries the tail wraps onto the head slot, which is only written while it is popped
    assign tail = head ^ count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= 1'b0;
            count <= '0;
        end else begin
            if (wr_en)
                slot[tail] <= wr_data;
            if (rd_en)
                head <= ~head;
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign rd_data = slot[head];
    assign valid   = (count != '0);
endmodule

// File: rtl/rd2r_sram_fifo.sv
// FIFO built on an external two-port SRAM with a two-entry output buffer.
// Define RD2R_SRAM_FIFO_MEMINIT_EN to zero the whole SRAM after every reset.
module rd2r_sram_fifo
    import rd2r_sram_fifo_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH + 3)
) (
    input  logic                 CK,
    input  logic                 RST,
    rd2r_sram_fifo_if.slave      bus,
    output logic [LW-1:0]        LEVEL,
    output logic                 INIT_DONE,
    output logic                 MEM_REN,
    output logic                 MEM_WEN,
    output logic [AW-1:0]        MEM_RA,
    output logic [AW-1:0]        MEM_WA,
    output logic [dataWidth-1:0] MEM_DI,
    input  logic [dataWidth-1:0] MEM_DOUT
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e        state, state_next;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] sram_count;
    logic          inflight;
    logic [1:0]    ob_count;
    logic          push, pop, rd_issue;
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
    logic [AW-1:0] init_addr;
    logic          init_wen;
`endif

    always_ff @(posedge CK) begin
        if (RST)
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
            state <= INIT;
`else
            state <= RUN;
`endif
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        INIT_DONE  = 1'b0;
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
        init_wen   = 1'b0;
`endif
        unique case (state)
            INIT: begin
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
                init_wen = !RST;
                if (init_addr == AW'(DEPTH - 1))
                    state_next = RUN;
`else
                state_next = RUN;
`endif
            end
            RUN: INIT_DONE = !RST;
        endcase
    end

`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
    always_ff @(posedge CK) begin
        if (RST || state != INIT)
            init_addr <= '0;
        else
            init_addr <= init_addr + AW'(1);
    end
`endif

    assign bus.I_READY = INIT_DONE && (sram_count < CW'(DEPTH));
    assign push        = bus.I_VALID && bus.I_READY;
    assign pop         = bus.O_VALID && bus.O_READY;
    // the entry popped this cycle frees its slot, so reads can be issued back to back
    assign rd_issue    = (sram_count != '0) &&
                         ((3'(ob_count) + 3'(inflight)) < (3'd2 + 3'(pop)));

    always_comb begin
        MEM_WEN = push;
        MEM_WA  = wptr;
        MEM_DI  = bus.I_DATA;
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
        if (init_wen) begin
            MEM_WEN = 1'b1;
            MEM_WA  = init_addr;
            MEM_DI  = '0;
        end
`endif
    end

    assign MEM_REN = rd_issue;
    assign MEM_RA  = rptr;

    always_ff @(posedge CK) begin
        if (RST) begin
            wptr       <= '0;
            rptr       <= '0;
            sram_count <= '0;
            inflight   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (rd_issue)
                rptr <= rptr + AW'(1);
            inflight <= rd_issue;
            case ({push, rd_issue})
                2'b10:   sram_count <= sram_count + CW'(1);
                2'b01:   sram_count <= sram_count - CW'(1);
                default: sram_count <= sram_count;
            endcase
        end
    end

    rd2r_sram_fifo_obuf #(
        .dataWidth(dataWidth)
    ) u_obuf (
        .clk    (CK),
        .rst    (RST),
        .wr_en  (inflight),
        .wr_data(MEM_DOUT),
        .rd_en  (pop),
        .rd_data(bus.O_DATA),
        .valid  (bus.O_VALID),
        .count  (ob_count)
    );

    assign LEVEL = LW'(sram_count) + LW'(inflight) + LW'(ob_count);

    a_no_rw_collision: assert property (@(posedge CK) disable iff (RST)
        !(MEM_REN && MEM_WEN && (MEM_RA == MEM_WA)));
endmodule

// File: tb/tb_rd2r_sram_fifo.sv
// Randomized bench for rd2r_sram_fifo against a queue model and a behavioural two-port SRAM.
`timescale 1ns/1ps
module tb_rd2r_sram_fifo;
    import rd2r_sram_fifo_pkg::*;

    localparam int unsigned DW    = DATA_WIDTH_DEFAULT;
    localparam int unsigned DEPTH = DEPTH_DEFAULT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = $clog2(DEPTH + 3);

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic [LW-1:0] LEVEL;
    logic          INIT_DONE, MEM_REN, MEM_WEN;
    logic [AW-1:0] MEM_RA, MEM_WA;
    logic [DW-1:0] MEM_DI, MEM_DOUT;

    always #5 CK = ~CK;

    rd2r_sram_fifo_if #(.dataWidth(DW)) bus ();

    rd2r_sram_fifo #(
        .dataWidth(DW),
        .DEPTH    (DEPTH)
    ) dut (
        .CK       (CK),
        .RST      (RST),
        .bus      (bus),
        .LEVEL    (LEVEL),
        .INIT_DONE(INIT_DONE),
        .MEM_REN  (MEM_REN),
        .MEM_WEN  (MEM_WEN),
        .MEM_RA   (MEM_RA),
        .MEM_WA   (MEM_WA),
        .MEM_DI   (MEM_DI),
        .MEM_DOUT (MEM_DOUT)
    );

    // two-port SRAM, read data valid the cycle after the read strobe
    logic [DW-1:0] sram [DEPTH];
    always @(posedge CK) begin
        if (MEM_WEN)
            sram[MEM_WA] <= MEM_DI;
        if (MEM_REN)
            MEM_DOUT <= sram[MEM_RA];
    end

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    int unsigned   n_push  = 0;
    int unsigned   n_pop   = 0;
    logic [DW-1:0] q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [DW-1:0] d);
        logic [63:0] f;
        f = '0;
        for (int unsigned i = 0; i < DW; i++)
            f[i % 64] ^= d[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int unsigned w = 0; w < (DW + 31) / 32; w++)
            d = (d << 32) | DW'($urandom);
        return d;
    endfunction

    // one clock: check outputs against the model, then apply this edge's handshakes to it
    task automatic step();
        bit            fire, take;
        logic [DW-1:0] din;
        fire = bus.I_VALID && bus.I_READY;
        take = bus.O_VALID && bus.O_READY;
        din  = bus.I_DATA;
        if (!RST) begin
            check_eq("level", 64'(LEVEL), 64'(q.size()));
            if (q.size() == 0)
                check_eq("o_valid_when_empty", 64'(bus.O_VALID), 64'd0);
            if (take && q.size() != 0)
                check_eq("o_data", fold(bus.O_DATA), fold(q[0]));
            if (q.size() < DEPTH)
                check_eq("i_ready_not_full", 64'(bus.I_READY), 64'd1);
            if (q.size() == DEPTH + 2)
                check_eq("i_ready_full", 64'(bus.I_READY), 64'd0);
        end
        if (fire) n_push++;
        if (take) n_pop++;
        @(posedge CK);
        if (RST) begin
            q.delete();
        end else begin
            if (take && q.size() != 0)
                void'(q.pop_front());
            if (fire)
                q.push_back(din);
        end
        @(negedge CK);
    endtask

    task automatic release_reset();
        RST = 1'b0;
        #1;
`ifdef RD2R_SRAM_FIFO_MEMINIT_EN
        begin
            int unsigned wen_cycles = 0;
            int unsigned addr_bad = 0, di_bad = 0, rdy_bad = 0;
            int          last_wen = -1;
            int          done_at  = -1;
            for (int c = 0; c < int'(DEPTH) + 20; c++) begin
                if (INIT_DONE) begin
                    done_at = c;
                    break;
                end
                if (MEM_WEN) begin
                    if (MEM_WA != AW'(wen_cycles)) addr_bad++;
                    if (MEM_DI != '0) di_bad++;
                    wen_cycles++;
                    last_wen = c;
                end
                if (bus.I_READY) rdy_bad++;
                @(posedge CK);
                #1;
            end
            check_eq("init_wen_cycles", 64'(wen_cycles), 64'(DEPTH));
            check_eq("init_addr_errors", 64'(addr_bad), 64'd0);
            check_eq("init_data_errors", 64'(di_bad), 64'd0);
            check_eq("init_i_ready_high", 64'(rdy_bad), 64'd0);
            check_eq("init_done_cycle", 64'(done_at), 64'(last_wen + 1));
        end
`else
        check_eq("init_done_on_release", 64'(INIT_DONE), 64'd1);
`endif
        @(negedge CK);
    endtask

    task automatic drain(input string tag);
        bus.I_VALID = 1'b0;
        bus.O_READY = 1'b1;
        for (int g = 0; g < 800 && q.size() != 0; g++)
            step();
        check_eq(tag, 64'(LEVEL), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, pbase, seq, stalls, p_in, p_out;

        bus.I_VALID = 1'b0;
        bus.I_DATA  = '0;
        bus.O_READY = 1'b0;
        RST         = 1'b1;
        repeat (3) @(negedge CK);
        check_eq("rst_o_valid", 64'(bus.O_VALID), 64'd0);
        check_eq("rst_level", 64'(LEVEL), 64'd0);
        check_eq("rst_i_ready", 64'(bus.I_READY), 64'd0);
        check_eq("rst_mem_ren", 64'(MEM_REN), 64'd0);
        check_eq("rst_mem_wen", 64'(MEM_WEN), 64'd0);
        check_eq("rst_init_done", 64'(INIT_DONE), 64'd0);
        release_reset();

        // single push into an empty FIFO: visible after the third edge
        bus.I_VALID = 1'b1;
        bus.I_DATA  = DW'(12'h155);
        bus.O_READY = 1'b1;
        step();
        bus.I_VALID = 1'b0;
        check_eq("lat_edge1", 64'(bus.O_VALID), 64'd0);
        step();
        check_eq("lat_edge2", 64'(bus.O_VALID), 64'd0);
        step();
        check_eq("lat_edge3", 64'(bus.O_VALID), 64'd1);
        check_eq("first_data", fold(bus.O_DATA), 64'h155);
        step();
        check_eq("single_level_back", 64'(LEVEL), 64'd0);

        // fill to capacity with the output stalled
        bus.O_READY = 1'b0;
        bus.I_VALID = 1'b1;
        base = n_push;
        for (int g = 0; g < 400 && (n_push - base) < DEPTH + 2; g++) begin
            bus.I_DATA = DW'(n_push - base);
            step();
        end
        check_eq("full_i_ready", 64'(bus.I_READY), 64'd0);
        check_eq("full_level", 64'(LEVEL), 64'(DEPTH + 2));
        repeat (3) step();
        check_eq("full_accepted", 64'(n_push - base), 64'(DEPTH + 2));
        pbase = n_pop;
        drain("full_drain_level");
        check_eq("full_popped", 64'(n_pop - pbase), 64'(DEPTH + 2));

        // streaming: one pop per cycle once primed, pointers wrap several times
        bus.I_VALID = 1'b1;
        bus.O_READY = 1'b1;
        seq    = 0;
        stalls = 0;
        base   = n_push;
        for (int c = 0; c < 1000; c++) begin
            pbase      = n_pop;
            bus.I_DATA = DW'(seq);
            seq++;
            step();
            if (c >= 10 && n_pop == pbase) stalls++;
        end
        check_eq("stream_stalls", 64'(stalls), 64'd0);
        check_eq("stream_pushes", 64'(n_push - base), 64'd1000);
        drain("stream_drain_level");

        // random traffic in fill-biased, drain-biased and balanced phases
        for (int ph = 0; ph < 3; ph++) begin
            p_in  = (ph == 0) ? 90 : (ph == 1) ? 30 : 50;
            p_out = (ph == 0) ? 25 : (ph == 1) ? 90 : 50;
            for (int c = 0; c < 1000; c++) begin
                bus.I_VALID = ($urandom_range(99) < p_in);
                bus.I_DATA  = rand_data();
                bus.O_READY = ($urandom_range(99) < p_out);
                step();
            end
        end
        drain("random_drain_level");

        // reset with ten entries held and a read in flight
        bus.O_READY = 1'b0;
        bus.I_VALID = 1'b1;
        base = n_push;
        for (int g = 0; g < 40 && (n_push - base) < 10; g++) begin
            bus.I_DATA = rand_data();
            step();
        end
        bus.I_VALID = 1'b0;
        bus.O_READY = 1'b1;
        step();
        check_eq("pre_rst_inflight", 64'(LEVEL), 64'd9);
        bus.O_READY = 1'b0;
        RST = 1'b1;
        step();
        check_eq("mid_rst_o_valid", 64'(bus.O_VALID), 64'd0);
        check_eq("mid_rst_level", 64'(LEVEL), 64'd0);
        check_eq("mid_rst_i_ready", 64'(bus.I_READY), 64'd0);
        release_reset();
        check_eq("post_rst_o_valid", 64'(bus.O_VALID), 64'd0);
        step();
        check_eq("post_rst_o_valid_late", 64'(bus.O_VALID), 64'd0);
        bus.I_VALID = 1'b1;
        bus.I_DATA  = DW'(16'hABC);
        bus.O_READY = 1'b1;
        step();
        bus.I_VALID = 1'b0;
        pbase = n_pop;
        for (int c = 0; c < 8; c++)
            step();
        check_eq("post_rst_pops", 64'(n_pop - pbase), 64'd1);
        check_eq("post_rst_level", 64'(LEVEL), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
